// File: rtl/cis_dvp_pkg.sv
// Shared types for the DVP sensor emulator: FSM states, pattern modes and the colour-bar level helper.
package cis_dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_FRONT
  } state_t;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_BAYER = 2'd3
  } mode_t;

  // Eight evenly spaced levels from 0 to full scale, truncated.
  function automatic logic [31:0] bar_value(input logic [2:0] bar, input int data_w);
    logic [31:0] full;
    full = (32'd1 << data_w) - 32'd1;
    return (32'(bar) * full) / 32'd7;
  endfunction

endpackage

// File: rtl/cis_dvp_timing.sv
// Frame timing engine: PCLK divider, pixel/line counters, frame FSM, run control and frame counter.
// Counters and state advance on the last divider count so new values appear with pclk_o low.
module cis_dvp_timing
  import cis_dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 8,
  parameter int PCLK_DIV    = 2,
  parameter int XW          = $clog2(H_ACTIVE + H_BLANK)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [15:0]   num_frames_i,
  output state_t        state_o,
  output logic [XW-1:0] x_o,
  output logic [15:0]   y_o,
  output logic          pclk_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [15:0]   frame_cnt_o,
  output logic          load_o
);

  localparam int DW = $clog2(PCLK_DIV);

  state_t        state_q, state_d, first_st;
  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          stop_q, stop_d;
  logic [15:0]   lines;
  logic          adv, x_last, y_last, frame_end, limit_hit, load;
  logic [15:0]   cnt_inc;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fcnt_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fcnt_q  <= fcnt_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    // Zero-length sync/porch phases are skipped entirely.
    first_st = ST_ACTIVE;
    if (V_BACK > 0) first_st = ST_VBACK;
    if (VSYNC_LINES > 0) first_st = ST_VSYNC;

    case (state_q)
      ST_VSYNC:  lines = 16'(VSYNC_LINES);
      ST_VBACK:  lines = 16'(V_BACK);
      ST_ACTIVE: lines = 16'(V_ACTIVE);
      ST_FRONT:  lines = 16'(V_FRONT);
      default:   lines = 16'd1;
    endcase

    x_last    = (x_q == XW'(H_ACTIVE + H_BLANK - 1));
    y_last    = (y_q == lines - 16'd1);
    adv       = (state_q != ST_IDLE) && (div_q == DW'(PCLK_DIV - 1));
    cnt_inc   = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
    limit_hit = (num_frames_i != 16'd0) && (({1'b0, fcnt_q} + 17'd1) == {1'b0, num_frames_i});

    state_d   = state_q;
    div_d     = div_q;
    x_d       = x_q;
    y_d       = y_q;
    fcnt_d    = fcnt_q;
    stop_d    = stop_q;
    frame_end = 1'b0;
    load      = 1'b0;

    if (state_q == ST_IDLE) begin
      div_d  = '0;
      x_d    = '0;
      y_d    = '0;
      stop_d = 1'b0;
      if (start_i) begin
        state_d = first_st;
        fcnt_d  = '0;
        load    = 1'b1;
      end
    end else begin
      if (stop_i) stop_d = 1'b1;
      div_d = adv ? '0 : div_q + 1'b1;
      if (adv) begin
        if (!x_last) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d = '0;
          if (!y_last) begin
            y_d = y_q + 16'd1;
          end else begin
            y_d = '0;
            case (state_q)
              ST_VSYNC:  state_d = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: if (V_FRONT > 0) state_d = ST_FRONT; else frame_end = 1'b1;
              default:   frame_end = 1'b1;
            endcase
          end
        end
      end
      if (frame_end) begin
        fcnt_d = cnt_inc;
        if (stop_q || stop_i || limit_hit) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else begin
          state_d = first_st;
          load    = 1'b1;
        end
      end
    end
  end

  assign state_o      = state_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign pclk_o       = busy_o && (div_q >= DW'(PCLK_DIV / 2));
  assign frame_done_o = frame_end;
  assign frame_cnt_o  = fcnt_q;
  assign load_o       = load;

endmodule

// File: rtl/cis_dvp_tx.sv
// Parallel DVP camera-sensor emulator: drives PCLK/VSYNC/HREF/D with ramp, bars, constant or Bayer checker.
// Pattern settings are captured at every frame start so mid-frame changes take effect next frame.
module cis_dvp_tx
  import cis_dvp_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 8,
  parameter int PCLK_DIV    = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [15:0]       num_frames_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] const_i,
  output logic              pclk_o,
  output logic              vsync_o,
  output logic              href_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int XW    = $clog2(H_ACTIVE + H_BLANK);
  localparam int BAR_W = H_ACTIVE / 8;

  state_t            state;
  logic [XW-1:0]     x;
  logic [15:0]       y;
  logic              load;
  mode_t             mode_q, mode_d;
  logic [DATA_W-1:0] const_q, const_d;
  logic [DATA_W-1:0] pix;
  logic [2:0]        bar;

  cis_dvp_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .V_ACTIVE   (V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT),
    .PCLK_DIV   (PCLK_DIV),
    .XW         (XW)
  ) u_timing (
    .clk_i       (wb_clk_i),
    .rstn_i      (wb_rstn_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .num_frames_i(num_frames_i),
    .state_o     (state),
    .x_o         (x),
    .y_o         (y),
    .pclk_o      (pclk_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .frame_cnt_o (frame_cnt_o),
    .load_o      (load)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      mode_q  <= MODE_RAMP;
      const_q <= '0;
    end else begin
      mode_q  <= mode_d;
      const_q <= const_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    const_d = const_q;
    if (load) begin
      mode_d  = mode_t'(mode_i);
      const_d = const_i;
    end
  end

  assign vsync_o = (state == ST_VSYNC);
  assign href_o  = (state == ST_ACTIVE) && (x < XW'(H_ACTIVE));

  always_comb begin
    bar = 3'(x / XW'(BAR_W));
    pix = '0;
    if (href_o) begin
      case (mode_q)
        MODE_RAMP:  pix = DATA_W'(x) + DATA_W'(y) + DATA_W'(frame_cnt_o);
        MODE_BARS:  pix = DATA_W'(bar_value(bar, DATA_W));
        MODE_CONST: pix = const_q;
        default:    pix = (x[0] ^ y[0]) ? ~const_q : const_q;
      endcase
    end
  end

  assign data_o = pix;

endmodule

// File: tb/tb_cis_dvp_tx.sv
// Directed bench for cis_dvp_tx with small frame geometry; expected pixels are queued per frame and popped at PCLK rise.
module tb_cis_dvp_tx;

  logic        wb_clk_i = 1'b0;
  logic        wb_rstn_i, start_i, stop_i;
  logic [15:0] num_frames_i;
  logic [1:0]  mode_i;
  logic [9:0]  const_i;
  logic        pclk_o, vsync_o, href_o, busy_o, frame_done_o;
  logic [9:0]  data_o;
  logic [15:0] frame_cnt_o;

  int total = 0;
  int bad   = 0;
  int href_cycles = 0;
  int vsync_cycles = 0;
  logic chk_en = 1'b1;
  logic pclk_prev = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] bars [8] = '{10'd0, 10'd146, 10'd292, 10'd438, 10'd584, 10'd730, 10'd876, 10'd1023};

  always #5 wb_clk_i = ~wb_clk_i;

  cis_dvp_tx #(
    .DATA_W(10), .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i), .start_i(start_i), .stop_i(stop_i),
    .num_frames_i(num_frames_i), .mode_i(mode_i), .const_i(const_i),
    .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .data_o(data_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic clk();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push_frame(input int mode, input logic [9:0] c, input int f);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        logic [9:0] v;
        case (mode)
          0:       v = 10'(x + y + f);
          1:       v = bars[x];
          2:       v = c;
          default: v = (((x ^ y) & 1) != 0) ? ~c : c;
        endcase
        exp_q.push_back(v);
      end
    end
  endtask

  // Counts clocks from the current one (1) to the cycle carrying the n-th frame_done pulse.
  task automatic run_done(input string tag, input int n, input int budget, output int cyc, output int idle);
    int seen = 0;
    cyc = 0;
    idle = 0;
    while (seen < n && cyc < budget) begin
      cyc++;
      if (!busy_o) idle++;
      if (frame_done_o) seen++;
      if (seen < n) clk();
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    clk();
    start_i = 1'b0;
  endtask

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      if (pclk_o && !pclk_prev && href_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL pix_extra got=%0d want=none", data_o);
        end else begin
          check("pix", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      if (!href_o) check("blank_data", 32'(data_o), 32'd0);
    end
    if (href_o) href_cycles++;
    if (vsync_o) vsync_cycles++;
    pclk_prev = pclk_o;
  end

  initial begin
    int cyc, idle, h0, v0, cnt;
    wb_rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    num_frames_i = 16'd0; mode_i = 2'd0; const_i = 10'd0;

    // 1: reset and idle
    repeat (3) clk();
    check("rst_ctl", 32'({vsync_o, href_o, pclk_o, busy_o, frame_done_o}), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_fcnt", 32'(frame_cnt_o), 32'd0);
    wb_rstn_i = 1'b1;
    cnt = 0;
    repeat (50) begin
      clk();
      if (pclk_o || busy_o || vsync_o || href_o) cnt++;
    end
    check("idle_static", 32'(cnt), 32'd0);

    // 2: single ramp frame
    num_frames_i = 16'd1; mode_i = 2'd0;
    push_frame(0, 10'd0, 0);
    h0 = href_cycles; v0 = vsync_cycles;
    pulse_start();
    check("s2_vsync_lat", 32'(vsync_o), 32'd1);
    check("s2_busy", 32'(busy_o), 32'd1);
    run_done("s2_done_seen", 1, 400, cyc, idle);
    check("s2_done_clk", 32'(cyc), 32'd168);
    check("s2_href_clks", 32'(href_cycles - h0), 32'd64);
    check("s2_vsync_clks", 32'(vsync_cycles - v0), 32'd24);
    clk();
    check("s2_idle", 32'(busy_o), 32'd0);
    check("s2_fcnt", 32'(frame_cnt_o), 32'd1);
    check("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: stop in IDLE ignored; three back-to-back frames; start while busy ignored
    stop_i = 1'b1; clk(); stop_i = 1'b0; clk();
    num_frames_i = 16'd3;
    push_frame(0, 10'd0, 0); push_frame(0, 10'd0, 1); push_frame(0, 10'd0, 2);
    pulse_start();
    run_done("s3_f1_seen", 1, 400, cyc, idle);
    check("s3_f1_clk", 32'(cyc), 32'd168);
    repeat (30) clk();
    pulse_start();
    check("s3_fcnt_mid", 32'(frame_cnt_o), 32'd1);
    run_done("s3_f3_seen", 2, 800, cyc, idle);
    check("s3_f3_clk", 32'(cyc), 32'd306);
    check("s3_no_gap", 32'(idle), 32'd0);
    clk();
    check("s3_idle", 32'(busy_o), 32'd0);
    check("s3_fcnt", 32'(frame_cnt_o), 32'd3);
    check("s3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: colour bars, then checker with start+stop in the same IDLE cycle
    num_frames_i = 16'd1; mode_i = 2'd1;
    push_frame(1, 10'd0, 0);
    pulse_start();
    run_done("s4_bars_seen", 1, 400, cyc, idle);
    clk();
    num_frames_i = 16'd2; mode_i = 2'd3; const_i = 10'h155;
    push_frame(3, 10'h155, 0); push_frame(3, 10'h155, 1);
    start_i = 1'b1; stop_i = 1'b1; clk(); start_i = 1'b0; stop_i = 1'b0;
    run_done("s4_chk_seen", 2, 800, cyc, idle);
    check("s4_chk_clk", 32'(cyc), 32'd336);
    clk();
    check("s4_fcnt", 32'(frame_cnt_o), 32'd2);
    check("s4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: continuous run stopped mid frame 2; mode change mid-frame has no effect
    num_frames_i = 16'd0; mode_i = 2'd0; const_i = 10'd0;
    push_frame(0, 10'd0, 0); push_frame(0, 10'd0, 1);
    pulse_start();
    run_done("s5_f1_seen", 1, 400, cyc, idle);
    repeat (60) clk();
    stop_i = 1'b1; clk(); stop_i = 1'b0;
    mode_i = 2'd2; const_i = 10'h3C3;
    run_done("s5_f2_seen", 1, 400, cyc, idle);
    clk();
    check("s5_idle", 32'(busy_o), 32'd0);
    check("s5_fcnt", 32'(frame_cnt_o), 32'd2);
    check("s5_q_empty", 32'(exp_q.size()), 32'd0);
    cnt = 0;
    repeat (30) begin
      clk();
      if (busy_o) cnt++;
    end
    check("s5_stays_idle", 32'(cnt), 32'd0);

    // 6: reset during ACTIVE, then a clean restart
    chk_en = 1'b0;
    num_frames_i = 16'd0; mode_i = 2'd0;
    pulse_start();
    run_done("s6_f1_seen", 1, 400, cyc, idle);
    cnt = 0;
    while (!href_o && cnt < 300) begin
      clk();
      cnt++;
    end
    check("s6_in_active", 32'(href_o), 32'd1);
    wb_rstn_i = 1'b0;
    clk();
    check("s6_rst_ctl", 32'({vsync_o, href_o, pclk_o, busy_o, frame_done_o}), 32'd0);
    check("s6_rst_data", 32'(data_o), 32'd0);
    check("s6_rst_fcnt", 32'(frame_cnt_o), 32'd0);
    wb_rstn_i = 1'b1;
    repeat (5) clk();
    chk_en = 1'b1;
    num_frames_i = 16'd1; mode_i = 2'd2; const_i = 10'h0AB;
    push_frame(2, 10'h0AB, 0);
    pulse_start();
    check("s6_vsync_lat", 32'(vsync_o), 32'd1);
    run_done("s6_done_seen", 1, 400, cyc, idle);
    check("s6_done_clk", 32'(cyc), 32'd168);
    clk();
    check("s6_fcnt", 32'(frame_cnt_o), 32'd1);
    check("s6_idle", 32'(busy_o), 32'd0);
    check("s6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
